// File: rtl/mac_tx_frm.sv
// GMII transmit framer: preamble/SFD, payload streamed from the packet buffer,
// optional zero pad to minimum length, optional CRC-32 FCS, then an enforced IFG.
module mac_tx_frm #(
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_FRAME    = 60,
    parameter int unsigned IFG_BYTES    = 12
) (
    input  logic                  i_gclk,
    input  logic                  i_rst_n,
    input  logic                  i_tx_start,
    input  logic [ADDR_WIDTH-1:0] i_data_st,
    input  logic [ADDR_WIDTH-1:0] i_data_ed,
    input  logic                  i_fcs_en,
    input  logic                  i_pad_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [7:0]            i_rd_byte,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_eth_txen,
    output logic                  o_eth_txer,
    output logic [7:0]            o_eth_txd
);

    localparam int unsigned LW = ADDR_WIDTH + 1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_PAD  = 3'd4;
    localparam logic [2:0] ST_FCS  = 3'd5;
    localparam logic [2:0] ST_IFG  = 3'd6;

    logic [2:0]            state_q,   state_d;
    logic [LW-1:0]         cnt_q,     cnt_d;
    logic [LW-1:0]         len_q,     len_d;
    logic [LW-1:0]         rd_left_q, rd_left_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [31:0]           crc_q,     crc_d;
    logic                  fcs_en_q,  fcs_en_d;
    logic                  pad_en_q,  pad_en_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  txen_q,    txen_d;
    logic [7:0]            txd_q,     txd_d;

    logic [ADDR_WIDTH-1:0] len_lo_c;
    logic [LW-1:0]         len_c;
    logic                  rd_step_c;
    logic                  crc_upd_c;
    logic                  end_pay_c;
    logic                  end_body_c;
    logic                  to_ifg_c;

    // Byte-wise reflected CRC-32 update, data consumed LSB first
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ data[i]) == 1'b1) ? 32'hEDB8_8320 : 32'h0000_0000);
        end
        return c;
    endfunction

    // A zero low-part length means the whole buffer (ed = st - 1)
    assign len_lo_c = i_data_ed - i_data_st + ADDR_WIDTH'(1);
    assign len_c    = (len_lo_c == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, len_lo_c};

    // Address leads the byte on txd by two cycles: one for the buffer, one for the txd register
    assign rd_step_c = (rd_left_q != '0) &&
                       (((state_q == ST_PRE) && (cnt_q == LW'(PREAMBLE_LEN - 1))) ||
                        (state_q == ST_SFD) || (state_q == ST_DATA));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        rd_left_d  = rd_left_q;
        rd_addr_d  = rd_addr_q;
        crc_d      = crc_q;
        fcs_en_d   = fcs_en_q;
        pad_en_d   = pad_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        txen_d     = txen_q;
        txd_d      = txd_q;
        crc_upd_c  = 1'b0;
        end_pay_c  = 1'b0;
        end_body_c = 1'b0;
        to_ifg_c   = 1'b0;

        if (rd_step_c) begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
            rd_left_d = rd_left_q - LW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    state_d   = ST_PRE;
                    cnt_d     = '0;
                    len_d     = len_c;
                    rd_left_d = len_c - LW'(1);
                    rd_addr_d = i_data_st;
                    fcs_en_d  = i_fcs_en;
                    pad_en_d  = i_pad_en;
                    crc_d     = 32'hFFFF_FFFF;
                    busy_d    = 1'b1;
                    txen_d    = 1'b1;
                    txd_d     = 8'h55;
                end
            end
            ST_PRE: begin
                if (cnt_q == LW'(PREAMBLE_LEN - 1)) begin
                    state_d = ST_SFD;
                    txd_d   = 8'hD5;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            ST_SFD: begin
                state_d   = ST_DATA;
                cnt_d     = '0;
                txd_d     = i_rd_byte;
                crc_upd_c = 1'b1;
            end
            ST_DATA: begin
                if (cnt_q == len_q - LW'(1)) begin
                    end_pay_c = 1'b1;
                end else begin
                    cnt_d     = cnt_q + LW'(1);
                    txd_d     = i_rd_byte;
                    crc_upd_c = 1'b1;
                end
            end
            ST_PAD: begin
                if (cnt_q == LW'(MIN_FRAME - 1)) begin
                    end_body_c = 1'b1;
                end else begin
                    cnt_d     = cnt_q + LW'(1);
                    txd_d     = 8'h00;
                    crc_upd_c = 1'b1;
                end
            end
            ST_FCS: begin
                if (cnt_q == LW'(3)) begin
                    to_ifg_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                    txd_d = ~crc_q[7:0];
                    crc_d = crc_q >> 8;
                end
            end
            ST_IFG: begin
                if (cnt_q == LW'(IFG_BYTES - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + LW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Payload finished: pad continues the byte index from L
        if (end_pay_c) begin
            if (pad_en_q && (len_q < LW'(MIN_FRAME))) begin
                state_d   = ST_PAD;
                cnt_d     = len_q;
                txd_d     = 8'h00;
                crc_upd_c = 1'b1;
            end else begin
                end_body_c = 1'b1;
            end
        end

        // CRC register already holds payload+pad; shift it out LSB first
        if (end_body_c) begin
            if (fcs_en_q) begin
                state_d = ST_FCS;
                cnt_d   = '0;
                txd_d   = ~crc_q[7:0];
                crc_d   = crc_q >> 8;
            end else begin
                to_ifg_c = 1'b1;
            end
        end

        if (to_ifg_c) begin
            state_d = ST_IFG;
            cnt_d   = '0;
            txen_d  = 1'b0;
            txd_d   = 8'h00;
            done_d  = 1'b1;
        end

        if (crc_upd_c) begin
            crc_d = crc_next(crc_q, txd_d);
        end
    end

    always_ff @(posedge i_gclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            rd_left_q <= '0;
            rd_addr_q <= '0;
            crc_q     <= 32'hFFFF_FFFF;
            fcs_en_q  <= 1'b0;
            pad_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            txen_q    <= 1'b0;
            txd_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rd_left_q <= rd_left_d;
            rd_addr_q <= rd_addr_d;
            crc_q     <= crc_d;
            fcs_en_q  <= fcs_en_d;
            pad_en_q  <= pad_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            txen_q    <= txen_d;
            txd_q     <= txd_d;
        end
    end

    assign o_rd_addr  = rd_addr_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_eth_txen = txen_q;
    assign o_eth_txer = 1'b0;
    assign o_eth_txd  = txd_q;

endmodule

// File: tb/tb_mac_tx_frm.sv
// Self-checking bench for mac_tx_frm: directed and random frames against a queue-based frame model.
module tb_mac_tx_frm;

    localparam int unsigned AW   = 11;
    localparam int unsigned NBUF = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tx_start = 1'b0;
    logic [AW-1:0] data_st = '0;
    logic [AW-1:0] data_ed = '0;
    logic          fcs_en = 1'b0;
    logic          pad_en = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;
    logic          busy, done, txen, txer;
    logic [7:0]    txd;

    logic [7:0]    mem [0:NBUF-1];
    logic [31:0]   crc_tbl [0:255];
    logic [7:0]    exp_q[$];
    logic [7:0]    got_q[$];
    logic [AW-1:0] adr_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_first, frame_last, prev_last;

    mac_tx_frm #(.ADDR_WIDTH(AW), .PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12)) dut (
        .i_gclk     (clk),
        .i_rst_n    (rst_n),
        .i_tx_start (tx_start),
        .i_data_st  (data_st),
        .i_data_ed  (data_ed),
        .i_fcs_en   (fcs_en),
        .i_pad_en   (pad_en),
        .o_rd_addr  (rd_addr),
        .i_rd_byte  (rd_byte),
        .o_busy     (busy),
        .o_done     (done),
        .o_eth_txen (txen),
        .o_eth_txer (txer),
        .o_eth_txd  (txd)
    );

    always #4 clk = ~clk;

    // Packet buffer: synchronous read, one cycle latency
    always_ff @(posedge clk) rd_byte <= mem[rd_addr];

    initial begin
        #1ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic int model_len(input logic [AW-1:0] st, input logic [AW-1:0] ed);
        return (((int'(ed) - int'(st)) % NBUF + NBUF) % NBUF) + 1;
    endfunction

    // Wire-frame model: preamble, SFD, payload, pad, FCS from a table-driven CRC
    task automatic build_exp(input logic [AW-1:0] st, input logic [AW-1:0] ed, input bit fcs, input bit pad);
        int len;
        logic [31:0] crc;
        logic [7:0] body[$];
        len = model_len(st, ed);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < len; k++) body.push_back(mem[(int'(st) + k) % NBUF]);
        if (pad) while (body.size() < 60) body.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (body[i]) crc = (crc >> 8) ^ crc_tbl[(crc[7:0] ^ body[i])];
        crc = ~crc;
        foreach (body[i]) exp_q.push_back(body[i]);
        if (fcs) for (int b = 0; b < 4; b++) exp_q.push_back(crc[8*b +: 8]);
    endtask

    task automatic run_frame(input logic [AW-1:0] st, input logic [AW-1:0] ed, input bit fcs,
                             input bit pad, input bit hold, input bit disturb, input string tag);
        int n, ifg, bad, mis, len;
        len = model_len(st, ed);
        build_exp(st, ed, fcs, pad);
        got_q.delete();
        adr_q.delete();
        data_st = st; data_ed = ed; fcs_en = fcs; pad_en = pad; tx_start = 1'b1;
        n = 0;
        do begin tick(); n++; end while (txen !== 1'b1 && n < 20);
        chk({tag, "_txen_rise"}, 32'(txen), 32'd1);
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        chk({tag, "_first_addr"}, 32'(rd_addr), 32'(st));
        if (!hold) tx_start = 1'b0;
        frame_first = cyc;
        bad = 0;
        while (txen === 1'b1 && got_q.size() < 5000) begin
            got_q.push_back(txd);
            if (adr_q.size() == 0 || adr_q[$] !== rd_addr) adr_q.push_back(rd_addr);
            if (done !== 1'b0 || busy !== 1'b1) bad++;
            if (disturb) begin
                tx_start = 1'($urandom);
                data_st  = AW'($urandom);
                data_ed  = AW'($urandom);
                fcs_en   = 1'($urandom);
                pad_en   = 1'($urandom);
            end
            tick();
        end
        frame_last = cyc - 1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_ifg_txd"}, 32'(txd), 32'd0);
        if (disturb) tx_start = 1'b1;
        ifg = 1;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (busy !== 1'b1) break;
            ifg++;
            if (done !== 1'b0 || txen !== 1'b0) bad++;
        end
        tx_start = hold;
        chk({tag, "_ifg_len"}, 32'(ifg), 32'd12);
        chk({tag, "_ctrl_glitch"}, 32'(bad), 32'd0);
        chk({tag, "_txen_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        mis = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mis++;
        chk({tag, "_bytes_bad"}, 32'(mis), 32'd0);
        chk({tag, "_addr_cnt"}, 32'(adr_q.size()), 32'(len));
        mis = 0;
        foreach (adr_q[k]) if (adr_q[k] !== AW'(int'(st) + k)) mis++;
        chk({tag, "_addr_seq_bad"}, 32'(mis), 32'd0);
        chk({tag, "_addr_hold"}, 32'(rd_addr), 32'(ed));
    endtask

    task automatic idle_check(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (txen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        chk({tag, "_stays_idle"}, 32'(bad), 32'd0);
    endtask

    initial begin
        string s;
        logic [31:0] c;
        logic [AW-1:0] st;
        int len, bad;

        for (int b = 0; b < 256; b++) begin
            c = 32'(b);
            for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tbl[b] = c;
        end
        for (int i = 0; i < NBUF; i++) mem[i] = 8'($urandom);
        s = "123456789";
        for (int i = 0; i < 9; i++) mem[16 + i] = s[i];

        // Reset values
        tick(); tick();
        chk("rst_txen", 32'(txen), 32'd0);
        chk("rst_txd", 32'(txd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_txer", 32'(txer), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        rst_n = 1'b1;
        tick();

        // Check string with known FCS
        run_frame(11'h010, 11'h018, 1'b1, 1'b0, 1'b0, 1'b0, "t1");
        chk("t1_len21", 32'(got_q.size()), 32'd21);
        if (got_q.size() == 21) begin
            chk("t1_fcs0", 32'(got_q[17]), 32'h26);
            chk("t1_fcs1", 32'(got_q[18]), 32'h39);
            chk("t1_fcs2", 32'(got_q[19]), 32'hF4);
            chk("t1_fcs3", 32'(got_q[20]), 32'hCB);
        end
        idle_check(3, "t1");

        // Address wrap through zero
        run_frame(11'h7FE, 11'h001, 1'b0, 1'b0, 1'b0, 1'b0, "t2");
        chk("t2_len12", 32'(got_q.size()), 32'd12);

        // Padding on and off
        run_frame(11'h300, 11'h309, 1'b1, 1'b1, 1'b0, 1'b0, "t3pad");
        chk("t3pad_len72", 32'(got_q.size()), 32'd72);
        run_frame(11'h300, 11'h309, 1'b1, 1'b0, 1'b0, 1'b0, "t3nopad");
        chk("t3nopad_len22", 32'(got_q.size()), 32'd22);

        // Start and input noise during the frame and the IFG
        run_frame(11'h400, 11'h41F, 1'b1, 1'b0, 1'b0, 1'b1, "t4noise");
        idle_check(5, "t4noise");

        // Held start: back-to-back frames with IFG honoured
        run_frame(11'h500, 11'h507, 1'b1, 1'b0, 1'b1, 1'b0, "t4holdA");
        prev_last = frame_last;
        run_frame(11'h600, 11'h604, 1'b1, 1'b1, 1'b0, 1'b0, "t4holdB");
        chk("t4_gap_low_cycles", 32'(frame_first - prev_last - 1), 32'd13);

        // Single byte
        run_frame(11'h100, 11'h100, 1'b0, 1'b0, 1'b0, 1'b0, "t5");
        chk("t5_len9", 32'(got_q.size()), 32'd9);

        // Reset in mid-payload
        data_st = 11'h200; data_ed = 11'h23F; fcs_en = 1'b1; pad_en = 1'b0; tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("t6_pre_txen", 32'(txen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_txen", 32'(txen), 32'd0);
        chk("t6_rst_txd", 32'(txd), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 1'b0 || txen !== 1'b0 || busy !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        tick();
        if (done !== 1'b0 || busy !== 1'b0) bad++;
        chk("t6_quiet_after_rst", 32'(bad), 32'd0);
        run_frame(11'h220, 11'h22B, 1'b1, 1'b1, 1'b0, 1'b0, "t6after");

        // Random frames
        for (int r = 0; r < 6; r++) begin
            st  = AW'($urandom);
            len = $urandom_range(1, 80);
            run_frame(st, AW'(int'(st) + len - 1), 1'($urandom), 1'($urandom), 1'b0, 1'b0, "rnd");
        end

        // Full buffer: ed = st - 1
        run_frame(11'h123, 11'h122, 1'b1, 1'b1, 1'b0, 1'b0, "full");
        chk("full_len", 32'(got_q.size()), 32'(8 + NBUF + 4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
